uart_transceiver: RTL and testbench



---
 rtl/uart_transceiver.sv | 178 +++++++++++++++++
 tb/tb_uart_transceiver.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_transceiver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_transceiver
// Brief    : Full-duplex 8N1 UART with ready/valid byte interfaces.
// Revision : 1.0 - initial release
// ============================================================================
module uart_transceiver #(
    parameter int CLOCK_FREQ = 125_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       data_in_valid,
    output logic       data_in_ready,
    output logic [7:0] data_out,
    output logic       data_out_valid,
    input  logic       data_out_ready,
    input  logic       serial_in,
    output logic       serial_out
);

    localparam int N  = CLOCK_FREQ / BAUD_RATE;
    localparam int CW = $clog2(N) + 1;

    localparam logic [CW-1:0] BIT_LAST  = CW'(N - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(N / 2 - 1);
    localparam logic [3:0]    LAST_BIT  = 4'd9;

    localparam logic [0:0] TX_IDLE = 1'b0;
    localparam logic [0:0] TX_SEND = 1'b1;
    localparam logic [0:0] RX_IDLE = 1'b0;
    localparam logic [0:0] RX_RECV = 1'b1;

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    logic [0:0]    tx_state_q, tx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [3:0]    tx_bit_q, tx_bit_d;
    logic [9:0]    tx_shift_q, tx_shift_d;
    logic          w_tx_last;
    logic          w_accept;

    // Ready rises during the final stop-bit cycle so a new frame can follow with no gap.
    assign w_tx_last     = (tx_state_q == TX_SEND) && (tx_bit_q == LAST_BIT) && (tx_cnt_q == BIT_LAST);
    assign data_in_ready = (tx_state_q == TX_IDLE) || w_tx_last;
    assign w_accept      = data_in_valid && data_in_ready;
    assign serial_out    = tx_shift_q[0];

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        if (tx_state_q == TX_SEND) begin
            if (tx_cnt_q == BIT_LAST) begin
                tx_cnt_d   = '0;
                tx_shift_d = {1'b1, tx_shift_q[9:1]};
                if (tx_bit_q == LAST_BIT) begin
                    tx_state_d = TX_IDLE;
                end else begin
                    tx_bit_d = tx_bit_q + 4'd1;
                end
            end else begin
                tx_cnt_d = tx_cnt_q + 1'b1;
            end
        end
        if (w_accept) begin
            tx_state_d = TX_SEND;
            tx_cnt_d   = '0;
            tx_bit_d   = '0;
            tx_shift_d = {1'b1, data_in, 1'b0};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
        end
    end

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    logic          rx_sync1_q, rx_sync2_q;
    logic [0:0]    rx_state_q, rx_state_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [3:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_shift_q, rx_shift_d;
    logic [7:0]    data_out_q, data_out_d;
    logic          valid_q, valid_d;
    logic          w_rx_done;
    logic [CW-1:0] w_rx_target;

    assign data_out       = data_out_q;
    assign data_out_valid = valid_q;
    assign w_rx_target    = (rx_bit_q == 4'd0) ? HALF_LAST : BIT_LAST;

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        w_rx_done  = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (!rx_sync2_q) begin
                    rx_state_d = RX_RECV;
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                end
            end
            default: begin
                if (rx_cnt_q == w_rx_target) begin
                    rx_cnt_d = '0;
                    // Sample 0 is the start bit and sample 9 the stop bit; neither is checked.
                    if ((rx_bit_q >= 4'd1) && (rx_bit_q <= 4'd8)) begin
                        rx_shift_d = {rx_sync2_q, rx_shift_q[7:1]};
                    end
                    if (rx_bit_q == LAST_BIT) begin
                        w_rx_done  = 1'b1;
                        rx_state_d = RX_IDLE;
                    end else begin
                        rx_bit_d = rx_bit_q + 4'd1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
        endcase
    end

    // A completing frame wins over a same-edge handshake: the newest byte is kept.
    always_comb begin
        data_out_d = data_out_q;
        valid_d    = valid_q;
        if (w_rx_done) begin
            data_out_d = rx_shift_q;
            valid_d    = 1'b1;
        end else if (valid_q && data_out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_sync1_q <= 1'b1;
            rx_sync2_q <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            data_out_q <= 8'h00;
            valid_q    <= 1'b0;
        end else begin
            rx_sync1_q <= serial_in;
            rx_sync2_q <= rx_sync1_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_transceiver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_uart_transceiver
// Brief    : Loopback bench for uart_transceiver at 4 clocks per bit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_transceiver;

    localparam int NB = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] data_in;
    logic       data_in_valid;
    logic       data_in_ready;
    logic [7:0] data_out;
    logic       data_out_valid;
    logic       data_out_ready;
    logic       serial_line;

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [7:0] exp_q[$];

    always #10 clk = ~clk;

    uart_transceiver #(
        .CLOCK_FREQ (50_000_000),
        .BAUD_RATE  (12_500_000)
    ) u_dut (
        .clk            (clk),
        .reset          (reset),
        .data_in        (data_in),
        .data_in_valid  (data_in_valid),
        .data_in_ready  (data_in_ready),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .data_out_ready (data_out_ready),
        .serial_in      (serial_line),
        .serial_out     (serial_line)
    );

    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        @(negedge clk);
        while (!data_in_ready && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 1000) begin
            total_cnt++;
            $display("FAIL send_wait: data_in_ready never rose, required 1");
        end
        data_in       = b;
        data_in_valid = 1'b1;
        @(posedge clk);
        exp_q.push_back(b);
        #1;
        data_in_valid = 1'b0;
        data_in       = 8'hFF;
    endtask

    task automatic wait_rx(input string name, input bit consume, output int cycles);
        logic [7:0] exp;
        cycles = 0;
        while (!data_out_valid && cycles < 200) begin
            @(negedge clk);
            cycles++;
        end
        total_cnt++;
        if (!data_out_valid || exp_q.size() == 0) begin
            $display("FAIL %s: no byte received (valid=%0b, pending=%0d)", name, data_out_valid, exp_q.size());
        end else begin
            exp = exp_q.pop_front();
            if (data_out !== exp) $display("FAIL %s: data_out=%h required %h", name, data_out, exp);
            else pass_cnt++;
        end
        if (consume) begin
            data_out_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            data_out_ready = 1'b0;
            total_cnt++;
            if (data_out_valid !== 1'b0) $display("FAIL %s_drop: data_out_valid=%b required 0", name, data_out_valid);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        #5;
        total_cnt += 4;
        if (serial_line !== 1'b1) $display("FAIL rst_serial_out: %b required 1", serial_line); else pass_cnt++;
        if (data_in_ready !== 1'b1) $display("FAIL rst_ready: %b required 1", data_in_ready); else pass_cnt++;
        if (data_out_valid !== 1'b0) $display("FAIL rst_valid: %b required 0", data_out_valid); else pass_cnt++;
        if (data_out !== 8'h00) $display("FAIL rst_data_out: %h required 00", data_out); else pass_cnt++;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_loopback;
        int cyc;
        send_byte(8'h64);
        wait_rx("loop_64", 1'b1, cyc);
        total_cnt++;
        // Line falls right after the accept edge; valid expected about 9.5*N+3 later.
        if (cyc < 40 || cyc > 44) $display("FAIL loop_latency: %0d cycles required 40..44", cyc);
        else pass_cnt++;
        send_byte(8'h58);
        wait_rx("loop_58", 1'b1, cyc);
        total_cnt++;
        if (cyc >= 150000) $display("FAIL loop_budget: %0d cycles required < 150000", cyc);
        else pass_cnt++;
    endtask

    task automatic test_tx_waveform;
        logic [9:0]  frame;
        logic [39:0] seen, want;
        int first_ready, cyc;
        frame = {1'b1, 8'hA5, 1'b0};
        for (int k = 0; k < 40; k++) want[k] = frame[k / NB];
        first_ready = 0;
        send_byte(8'hA5);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            seen[k-1] = serial_line;
            if (first_ready == 0 && data_in_ready) first_ready = k;
        end
        total_cnt += 2;
        if (seen !== want) $display("FAIL tx_wave: saw %h required %h", seen, want); else pass_cnt++;
        if (first_ready !== 40) $display("FAIL tx_ready_return: cycle %0d required 40", first_ready); else pass_cnt++;
        wait_rx("tx_wave_rx", 1'b1, cyc);
    endtask

    task automatic test_back_to_back;
        logic [9:0]  f1, f2;
        logic [79:0] seen, want;
        logic [7:0]  exp;
        int acc2, got;
        f1 = {1'b1, 8'h01, 1'b0};
        f2 = {1'b1, 8'h80, 1'b0};
        for (int k = 0; k < 80; k++) want[k] = (k < 40) ? f1[k / NB] : f2[(k - 40) / NB];
        acc2 = 0;
        got  = 0;
        @(negedge clk);
        data_in       = 8'h01;
        data_in_valid = 1'b1;
        @(posedge clk);
        exp_q.push_back(8'h01);
        #1;
        data_in = 8'h80;
        for (int k = 1; k <= 120; k++) begin
            @(negedge clk);
            if (data_out_ready) data_out_ready = 1'b0;
            if (k <= 80) seen[k-1] = serial_line;
            if (acc2 != 0 && k == acc2 + 1) data_in_valid = 1'b0;
            if (acc2 == 0 && data_in_ready && data_in_valid) begin
                acc2 = k;
                exp_q.push_back(8'h80);
            end
            if (data_out_valid && !data_out_ready) begin
                total_cnt++;
                if (exp_q.size() == 0) begin
                    $display("FAIL b2b_rx: unexpected byte %h", data_out);
                end else begin
                    exp = exp_q.pop_front();
                    if (data_out !== exp) $display("FAIL b2b_rx: data_out=%h required %h", data_out, exp);
                    else pass_cnt++;
                end
                data_out_ready = 1'b1;
                got++;
            end
        end
        @(negedge clk);
        data_out_ready = 1'b0;
        data_in_valid  = 1'b0;
        total_cnt += 3;
        if (acc2 !== 40) $display("FAIL b2b_accept: second accept at %0d required 40", acc2); else pass_cnt++;
        if (seen !== want) $display("FAIL b2b_wave: saw %h required %h", seen, want); else pass_cnt++;
        if (got !== 2) $display("FAIL b2b_count: %0d bytes required 2", got); else pass_cnt++;
    endtask

    task automatic test_overrun;
        int cyc, drops;
        logic [7:0] exp;
        send_byte(8'h11);
        wait_rx("ovr_first", 1'b0, cyc);
        send_byte(8'h22);
        drops = 0;
        repeat (60) begin
            @(negedge clk);
            if (!data_out_valid) drops++;
        end
        total_cnt += 2;
        if (drops !== 0) $display("FAIL ovr_valid_held: dropped %0d cycles required 0", drops); else pass_cnt++;
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
        if (data_out !== exp) $display("FAIL ovr_data: data_out=%h required %h", data_out, exp); else pass_cnt++;
    endtask

    task automatic test_reset_midframe;
        int cyc, spurious;
        send_byte(8'h99);
        repeat (20) @(negedge clk);
        reset = 1'b1;
        #1;
        total_cnt += 3;
        if (serial_line !== 1'b1) $display("FAIL mid_rst_serial_out: %b required 1", serial_line); else pass_cnt++;
        if (data_out_valid !== 1'b0) $display("FAIL mid_rst_valid: %b required 0", data_out_valid); else pass_cnt++;
        if (data_in_ready !== 1'b1) $display("FAIL mid_rst_ready: %b required 1", data_in_ready); else pass_cnt++;
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        spurious = 0;
        repeat (60) begin
            @(negedge clk);
            if (data_out_valid) spurious++;
        end
        total_cnt++;
        if (spurious !== 0) $display("FAIL mid_rst_partial: valid high %0d cycles required 0", spurious);
        else pass_cnt++;
        send_byte(8'h3C);
        wait_rx("mid_rst_3c", 1'b1, cyc);
    endtask

    initial begin
        reset          = 1'b1;
        data_in        = 8'h00;
        data_in_valid  = 1'b0;
        data_out_ready = 1'b0;
        test_reset();
        test_loopback();
        test_tx_waveform();
        test_back_to_back();
        test_overrun();
        test_reset_midframe();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
